// File: rtl/bram_dp_responder.sv
// Dual-port 32-bit block-RAM responder: port A and port B with byte enables, read-first,
// 1 or 2 cycle read latency. Optional collision counter built when BRAM_COLLISION_CNT_EN is defined.
module bram_dp_responder #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rsta,
    input  logic        i_ena,
    input  logic [31:0] i_addra,
    input  logic [31:0] i_dina,
    input  logic [3:0]  i_wea,
    output logic [31:0] o_douta,
    input  logic        i_rstb,
    input  logic        i_enb,
    input  logic [31:0] i_addrb,
    input  logic [31:0] i_dinb,
    input  logic [3:0]  i_web,
    output logic [31:0] o_doutb,
    output logic        o_oor_err,
    output logic [15:0] o_coll_cnt
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_douta;
    logic [31:0]   r_doutb;
    logic          r_oor_err;

    logic          w_a_in;
    logic          w_b_in;
    logic          w_a_ok;
    logic          w_b_ok;
    logic [AW-1:0] w_a_idx;
    logic [AW-1:0] w_b_idx;
    logic [3:0]    w_a_we;
    logic [3:0]    w_b_we;
    logic [31:0]   w_a_rd;
    logic [31:0]   w_b_rd;

    assign w_a_in  = (i_addra < LIMIT);
    assign w_b_in  = (i_addrb < LIMIT);
    assign w_a_ok  = i_ena && w_a_in;
    assign w_b_ok  = i_enb && w_b_in;
    assign w_a_idx = i_addra[AW+1:2];
    assign w_b_idx = i_addrb[AW+1:2];
    assign w_a_we  = i_wea & {4{w_a_ok}};
    assign w_b_we  = i_web & {4{w_b_ok}};
    assign w_a_rd  = w_a_ok ? r_mem[w_a_idx] : 32'h0;
    assign w_b_rd  = w_b_ok ? r_mem[w_b_idx] : 32'h0;

    // Port B lanes are scheduled first so port A overrides them on a shared word.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_b_we[i]) r_mem[w_b_idx][8*i +: 8] <= i_dinb[8*i +: 8];
            if (w_a_we[i]) r_mem[w_a_idx][8*i +: 8] <= i_dina[8*i +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_oor_err <= 1'b0;
        end else if ((i_ena && !w_a_in) || (i_enb && !w_b_in)) begin
            r_oor_err <= 1'b1;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [31:0] r_a_s1;
            logic [31:0] r_b_s1;
            logic        r_a_v1;
            logic        r_b_v1;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_a_s1 <= 32'h0;
                    r_b_s1 <= 32'h0;
                    r_a_v1 <= 1'b0;
                    r_b_v1 <= 1'b0;
                end else begin
                    r_a_v1 <= i_ena;
                    r_b_v1 <= i_enb;
                    if (i_ena) r_a_s1 <= w_a_rd;
                    if (i_enb) r_b_s1 <= w_b_rd;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_douta <= 32'h0;
                    r_doutb <= 32'h0;
                end else begin
                    if (i_rsta)      r_douta <= 32'h0;
                    else if (r_a_v1) r_douta <= r_a_s1;
                    if (i_rstb)      r_doutb <= 32'h0;
                    else if (r_b_v1) r_doutb <= r_b_s1;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_douta <= 32'h0;
                    r_doutb <= 32'h0;
                end else begin
                    if (i_rsta)     r_douta <= 32'h0;
                    else if (i_ena) r_douta <= w_a_rd;
                    if (i_rstb)     r_doutb <= 32'h0;
                    else if (i_enb) r_doutb <= w_b_rd;
                end
            end
        end
    endgenerate

`ifdef BRAM_COLLISION_CNT_EN
    logic        w_coll;
    logic [15:0] r_coll_cnt;

    assign w_coll = w_a_ok && w_b_ok && (w_a_idx == w_b_idx) && ((|i_wea) || (|i_web));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_coll_cnt <= 16'h0;
        end else if (w_coll && (r_coll_cnt != 16'hFFFF)) begin
            r_coll_cnt <= r_coll_cnt + 16'd1;
        end
    end

    assign o_coll_cnt = r_coll_cnt;
`else
    assign o_coll_cnt = 16'h0;
`endif

    assign o_douta   = r_douta;
    assign o_doutb   = r_doutb;
    assign o_oor_err = r_oor_err;

endmodule

// File: tb/tb_bram_dp_responder.sv
// Bench for bram_dp_responder: READ_LAT=1 and READ_LAT=2 instances share one stimulus stream
// and are checked every cycle against a word-array model, plus literal directed expectations.
module tb_bram_dp_responder;
    localparam int unsigned DEPTH = 256;
`ifdef BRAM_COLLISION_CNT_EN
    localparam int COLL_ON = 1;
`else
    localparam int COLL_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rsta, ena, rstb, enb;
    logic [31:0] addra, dina, addrb, dinb;
    logic [3:0]  wea, web;
    logic [31:0] douta1, doutb1, douta2, doutb2;
    logic        oor1, oor2;
    logic [15:0] cnt1, cnt2;

    always #5 clk = ~clk;

    bram_dp_responder #(.DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rsta(rsta), .i_ena(ena), .i_addra(addra), .i_dina(dina), .i_wea(wea), .o_douta(douta1),
        .i_rstb(rstb), .i_enb(enb), .i_addrb(addrb), .i_dinb(dinb), .i_web(web), .o_doutb(doutb1),
        .o_oor_err(oor1), .o_coll_cnt(cnt1)
    );

    bram_dp_responder #(.DEPTH(DEPTH), .READ_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rsta(rsta), .i_ena(ena), .i_addra(addra), .i_dina(dina), .i_wea(wea), .o_douta(douta2),
        .i_rstb(rstb), .i_enb(enb), .i_addrb(addrb), .i_dinb(dinb), .i_web(web), .o_doutb(doutb2),
        .o_oor_err(oor2), .o_coll_cnt(cnt2)
    );

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    // Reference model state.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] exp_a1, exp_b1, exp_a2, exp_b2;
    bit          exp_oor;
    int          exp_cnt;
    int          cyc = 0;
    int          rst_t = -1;
    bit          ha_en [int];
    bit          hb_en [int];
    logic [31:0] ha_rd [int];
    logic [31:0] hb_rd [int];
    bit          m_aok, m_bok;
    int          m_ai, m_bi;
    logic [31:0] m_rda, m_rdb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int w);
        return 32'hA5000000 ^ (32'(w) * 32'h00010203);
    endfunction

    always @(negedge rst_n) begin
        exp_a1 = 0; exp_b1 = 0; exp_a2 = 0; exp_b2 = 0;
        exp_oor = 0; exp_cnt = 0;
        rst_t = cyc - 1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_a1 = 0; exp_b1 = 0; exp_a2 = 0; exp_b2 = 0;
            exp_oor = 0; exp_cnt = 0;
            rst_t = cyc;
        end else begin
            m_aok = ena && (addra < DEPTH * 4);
            m_bok = enb && (addrb < DEPTH * 4);
            m_ai  = int'((addra >> 2) % DEPTH);
            m_bi  = int'((addrb >> 2) % DEPTH);
            m_rda = m_aok ? m_mem[m_ai] : 32'h0;
            m_rdb = m_bok ? m_mem[m_bi] : 32'h0;
            if ((ena && !m_aok) || (enb && !m_bok)) exp_oor = 1;
            if (COLL_ON == 1 && m_aok && m_bok && m_ai == m_bi && (wea != 0 || web != 0)
                && exp_cnt < 65535) exp_cnt++;
            for (int i = 0; i < 4; i++) begin
                if (m_bok && web[i]) m_mem[m_bi][8*i +: 8] = dinb[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                if (m_aok && wea[i]) m_mem[m_ai][8*i +: 8] = dina[8*i +: 8];
            end
            ha_en[cyc] = ena; ha_rd[cyc] = m_rda;
            hb_en[cyc] = enb; hb_rd[cyc] = m_rdb;
            if (rsta) exp_a1 = 0; else if (ena) exp_a1 = m_rda;
            if (rstb) exp_b1 = 0; else if (enb) exp_b1 = m_rdb;
            // Two-cycle port returns the read issued on the previous edge, unless a reset came since.
            if (rsta) exp_a2 = 0;
            else if (cyc - 1 > rst_t && ha_en.exists(cyc - 1) && ha_en[cyc - 1])
                exp_a2 = ha_rd[cyc - 1];
            if (rstb) exp_b2 = 0;
            else if (cyc - 1 > rst_t && hb_en.exists(cyc - 1) && hb_en[cyc - 1])
                exp_b2 = hb_rd[cyc - 1];
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("l1_douta", douta1, exp_a1);
            check("l1_doutb", doutb1, exp_b1);
            check("l2_douta", douta2, exp_a2);
            check("l2_doutb", doutb2, exp_b2);
            check("l1_oor", 32'(oor1), 32'(exp_oor));
            check("l2_oor", 32'(oor2), 32'(exp_oor));
            check("l1_coll", 32'(cnt1), 32'(exp_cnt));
            check("l2_coll", 32'(cnt2), 32'(exp_cnt));
        end
    end

    task automatic set_idle();
        rsta = 0; ena = 0; addra = 0; dina = 0; wea = 0;
        rstb = 0; enb = 0; addrb = 0; dinb = 0; web = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        #2 rst_n = 0;
        #2 rst_n = 1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 99);
        if (r < 60)      a = 32'($urandom_range(0, 7)) << 2;
        else if (r < 95) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        else             a = 32'($urandom) | 32'h400;
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        set_idle();
        repeat (3) step();
        check("rst_douta1", douta1, 32'h0);
        check("rst_doutb2", doutb2, 32'h0);
        check("rst_oor", 32'(oor1), 32'h0);
        check("rst_coll", 32'(cnt2), 32'h0);
        rst_n = 1;

        // Fill memory with known contents before anything is compared.
        for (int w = 0; w < DEPTH / 2; w++) begin
            ena = 1; addra = 32'(w) << 2; dina = init_val(w); wea = 4'hF;
            enb = 1; addrb = 32'(w + DEPTH / 2) << 2; dinb = init_val(w + DEPTH / 2); web = 4'hF;
            step();
        end
        set_idle();
        pulse_rst();
        step();
        chk_on = 1;

        // T1: B writes, A reads the next cycle.
        enb = 1; addrb = 32'h10; dinb = 32'h11223344; web = 4'hF;
        step();
        set_idle(); ena = 1; addra = 32'h10;
        step();
        check("t1_douta1", douta1, 32'h11223344);
        check("t1_model", exp_a1, 32'h11223344);
        set_idle();
        step();
        check("t1_douta2", douta2, 32'h11223344);

        // T2: single-byte write over an existing word.
        ena = 1; addra = 32'h0; dina = 32'hAABBCCDD; wea = 4'hF;
        step();
        set_idle(); enb = 1; addrb = 32'h0; dinb = 32'h00000055; web = 4'b0001;
        step();
        set_idle(); ena = 1; addra = 32'h0;
        step();
        check("t2_douta1", douta1, 32'hAABBCC55);
        set_idle(); ena = 1; addra = 32'h0; rsta = 1;
        step();
        check("t2_rsta", douta1, 32'h0);
        set_idle();

        // T3: full-word collision, port A wins.
        ena = 1; addra = 32'h8; dina = 32'hFFFFFFFF; wea = 4'hF;
        enb = 1; addrb = 32'h8; dinb = 32'h12345678; web = 4'hF;
        step();
        check("t3_coll", 32'(cnt1), (COLL_ON == 1) ? 32'd1 : 32'd0);
        set_idle(); enb = 1; addrb = 32'h8;
        step();
        check("t3_doutb1", doutb1, 32'hFFFFFFFF);
        set_idle();

        // T4: out-of-range read and write; 0x404 aliases word 1 if the range check is missing.
        ena = 1; addra = 32'h400;
        enb = 1; addrb = 32'h404; dinb = 32'hDEADBEEF; web = 4'hF;
        step();
        check("t4_douta1", douta1, 32'h0);
        check("t4_oor", 32'(oor1), 32'h1);
        set_idle(); ena = 1; addra = 32'h4;
        step();
        check("t4_mem", douta1, init_val(1));
        check("t4_oor_sticky", 32'(oor2), 32'h1);
        set_idle();

        // T5: two-cycle latency, then a reset cancelling an in-flight read.
        ena = 1; addra = 32'h4; dina = 32'hCAFEF00D; wea = 4'hF;
        step();
        set_idle(); ena = 1; addra = 32'h4;
        step();
        check("t5_l1", douta1, 32'hCAFEF00D);
        check("t5_l2_early", douta2, init_val(1));
        set_idle();
        step();
        check("t5_l2", douta2, 32'hCAFEF00D);
        ena = 1; addra = 32'h8;
        step();
        set_idle();
        pulse_rst();
        step();
        check("t5_cancel_l2", douta2, 32'h0);
        check("t5_cancel_l1", douta1, 32'h0);
        check("t5_oor_clr", 32'(oor1), 32'h0);
        step();
        check("t5_hold_l2", douta2, 32'h0);

        // T6: PE-style read burst with a trailing write burst.
        for (int k = 0; k < 11; k++) begin
            set_idle();
            if (k < 8) begin ena = 1; addra = 32'(k) << 2; end
            if (k >= 3) begin
                enb = 1; addrb = 32'(k - 3) << 2; dinb = 32'h100 + 32'(k - 3); web = 4'hF;
            end
            step();
        end
        set_idle();
        for (int k = 0; k < 8; k++) begin
            ena = 1; addra = 32'(k) << 2;
            step();
            check("t6_land", douta1, 32'h100 + 32'(k));
        end
        check("t6_coll", 32'(cnt1), 32'h0);
        set_idle();
        step();

        // Randomized traffic, mostly on a few words to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            ena = ($urandom_range(0, 9) < 7); enb = ($urandom_range(0, 9) < 7);
            addra = rnd_addr(); addrb = rnd_addr();
            dina = $urandom; dinb = $urandom;
            wea = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            web = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            rsta = ($urandom_range(0, 19) == 0); rstb = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) pulse_rst();
            step();
        end
        set_idle();
        repeat (3) step();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
